// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}; a lit segment is 1 before polarity inversion.
package seg7_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  typedef enum logic [1:0] {Slot0, Slot1, Slot2, Slot3} scan_state_e;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b000_0000;

  localparam logic [SEG_W-1:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bit i set: digit i is a leading zero and has no decimal point, so it stays dark.
  function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [DIGITS*DIGIT_W-1:0] data,
                                                      input logic [DIGITS-1:0]         dps);
    logic [DIGITS-1:0] mask;
    logic              all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (data[i*DIGIT_W +: DIGIT_W] == '0);
      mask[i]  = all_zero && !dps[i];
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder ({g,f,e,d,c,b,a}, lit = 1).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex,
  output logic [SEG_W-1:0]   seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with per-frame tear-free latch and ghost blanking.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIV_CNT     = 50000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [DIGITS*DIGIT_W-1:0]  data_in,
  input  logic [DIGITS-1:0]          dp_in,
  output logic [1:0]                 state,
  output logic [SEG_W-1:0]           seg,
  output logic                       dp,
  output logic                       frame_tick
);

  localparam int unsigned CNT_W = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [SEG_W-1:0] SEG_RST   = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic             DP_RST    = SEG_ACT_LOW;

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  scan_state_e               state_q, state_d;
  logic [DIGITS*DIGIT_W-1:0] sh_data_q, sh_data_d;
  logic [DIGITS-1:0]         sh_dp_q, sh_dp_d;
  logic [SEG_W-1:0]          seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      frame_tick_q;
  logic                      slot_tick, frame_load;
  logic [DIGIT_W-1:0]        digit_sel;
  logic                      dp_sel;
  logic [SEG_W-1:0]          seg_dec;
  logic                      lz_off;
  logic                      lit;

  assign slot_tick  = (cnt_q == CNT_MAX);
  assign frame_load = slot_tick && (state_q == Slot3);

  always_comb begin
    cnt_d     = slot_tick ? '0 : cnt_q + 1'b1;
    state_d   = slot_tick ? scan_state_e'(state_q + 2'd1) : state_q;
    sh_data_d = frame_load ? data_in : sh_data_q;
    sh_dp_d   = frame_load ? dp_in : sh_dp_q;
  end

  // The output register is fed from next-cycle state, so the visible pattern always
  // matches the visible slot and slot 0 shows the freshly latched frame.
  assign digit_sel = sh_data_d[{state_d, 2'b00} +: DIGIT_W];
  assign dp_sel    = sh_dp_d[state_d];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digit_sel),
    .seg (seg_dec)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_mask;
  assign lz_mask = lz_blank_mask(sh_data_d, sh_dp_d);
  assign lz_off  = lz_mask[state_d];
`else
  assign lz_off = 1'b0;
`endif

  assign lit = en && (cnt_d >= BLANK_LIM) && !lz_off;

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    if (lit) begin
      seg_d = seg_dec;
      dp_d  = dp_sel;
    end
    if (SEG_ACT_LOW) begin
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      state_q      <= Slot0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      seg_q        <= SEG_RST;
      dp_q         <= DP_RST;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_load;
    end
  end

  assign state      = state_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: two configurations driven with shared random stimulus, each checked
// against a cycle-count reference model of the display timing.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;

  logic [1:0] state_a, state_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, ft_a, ft_b;

  localparam int DIV_A = 4, BLK_A = 1;
  localparam int DIV_B = 5, BLK_B = 2;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIV_CNT(DIV_A), .BLANK_CYC(BLK_A), .SEG_ACT_LOW(1'b0)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .state      (state_a),
    .seg        (seg_a),
    .dp         (dp_a),
    .frame_tick (ft_a)
  );

  seg7_scan_ctrl #(.DIV_CNT(DIV_B), .BLANK_CYC(BLK_B), .SEG_ACT_LOW(1'b1)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .state      (state_b),
    .seg        (seg_b),
    .dp         (dp_b),
    .frame_tick (ft_b)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  int          cyc_a = 0, cyc_b = 0;
  logic [15:0] sh_a = '0, sh_b = '0;
  logic [3:0]  shdp_a = '0, shdp_b = '0;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected outputs for the cycle numbered cyc since reset release.
  function automatic exp_t model_out(input int cyc, input int div, input int blank,
                                     input bit act_low, input logic [15:0] sh,
                                     input logic [3:0] shdp, input logic en_s, input bit ft);
    exp_t r;
    int   slot;
    int   pos;
    bit   lit;
    logic [6:0] s;
    logic d;
    slot = (cyc / div) % 4;
    pos  = cyc % div;
    lit  = en_s && (pos >= blank);
`ifdef SEG7_LZ_BLANK_EN
    if (slot > 0 && !shdp[slot] && ((sh >> (slot * 4)) == 16'h0)) lit = 1'b0;
`endif
    s = 7'h00;
    d = 1'b0;
    if (lit) begin
      s = hexseg(sh[slot*4 +: 4]);
      d = shdp[slot];
    end
    if (act_low) begin
      s = ~s;
      d = ~d;
    end
    r.st  = 2'(slot);
    r.seg = s;
    r.dp  = d;
    r.ft  = ft;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_a = 0;  cyc_b = 0;
      sh_a = '0;  sh_b = '0;
      shdp_a = '0; shdp_b = '0;
      q_a.delete();
      q_b.delete();
    end else begin
      bit fa, fb;
      cyc_a++;
      cyc_b++;
      fa = (cyc_a % (4 * DIV_A)) == 0;
      fb = (cyc_b % (4 * DIV_B)) == 0;
      if (fa) begin sh_a = data_in; shdp_a = dp_in; end
      if (fb) begin sh_b = data_in; shdp_b = dp_in; end
      q_a.push_back(model_out(cyc_a, DIV_A, BLK_A, 1'b0, sh_a, shdp_a, en, fa));
      q_b.push_back(model_out(cyc_b, DIV_B, BLK_B, 1'b1, sh_b, shdp_b, en, fb));
    end
  end

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got st=%0d seg=%h dp=%b ft=%b, want st=%0d seg=%h dp=%b ft=%b",
               name, $time, act.st, act.seg, act.dp, act.ft, exp.st, exp.seg, exp.dp, exp.ft);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (q_a.size() > 0) compare("cfg_a", {state_a, seg_a, dp_a, ft_a}, q_a.pop_front());
      if (q_b.size() > 0) compare("cfg_b", {state_b, seg_b, dp_b, ft_b}, q_b.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    bit found;
    rst_n   = 1'b0;
    en      = 1'b1;
    data_in = 16'h12AF;
    dp_in   = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    tick(3 * 4 * DIV_B);

    // Tear-free latch: change data while config A is in slot 1.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (state_a == 2'd1) found = 1'b1;
      else tick(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_slot1: state_a=%0d, required 1 within 40 cycles", state_a);
    end
    data_in = 16'h0000;
    tick(2 * 4 * DIV_B);

    // Asynchronous reset mid-count.
    data_in = 16'h9876;
    tick(7);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("rst_a", {state_a, seg_a, dp_a, ft_a}, {2'd0, 7'h00, 1'b0, 1'b0});
    compare("rst_b", {state_b, seg_b, dp_b, ft_b}, {2'd0, 7'h7F, 1'b1, 1'b0});
    tick(2);
    rst_n = 1'b1;
    tick(2 * 4 * DIV_B);

    // Display disable while scanning continues, then re-enable.
    en = 1'b0;
    tick(2 * 4 * DIV_B);
    en = 1'b1;
    tick(2 * 4 * DIV_B);

    // Leading-zero patterns (plain zeros when the feature is off).
    data_in = 16'h0042; dp_in = 4'b0000; tick(3 * 4 * DIV_B);
    data_in = 16'h0000; dp_in = 4'b0000; tick(3 * 4 * DIV_B);
    data_in = 16'h0000; dp_in = 4'b0100; tick(3 * 4 * DIV_B);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) data_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) data_in = {8'h00, 8'($urandom)};
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 23) == 0) en = ~en;
      tick(1);
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
